// File: rtl/ntps_axi_regbank_if.sv
// AXI4-Lite bus bundle for the ntps register bank (32-bit data, 5-bit address).
interface ntps_axi_regbank_if;
  logic [4:0]  axi_awaddr;
  logic [2:0]  axi_awprot;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wvalid;
  logic        axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready;
  logic [4:0]  axi_araddr;
  logic [2:0]  axi_arprot;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rvalid;
  logic        axi_rready;

  modport slave (
    input  axi_awaddr, axi_awprot, axi_awvalid,
    output axi_awready,
    input  axi_wdata, axi_wstrb, axi_wvalid,
    output axi_wready,
    output axi_bresp, axi_bvalid,
    input  axi_bready,
    input  axi_araddr, axi_arprot, axi_arvalid,
    output axi_arready,
    output axi_rdata, axi_rresp, axi_rvalid,
    input  axi_rready
  );

  modport master (
    output axi_awaddr, axi_awprot, axi_awvalid,
    input  axi_awready,
    output axi_wdata, axi_wstrb, axi_wvalid,
    input  axi_wready,
    input  axi_bresp, axi_bvalid,
    output axi_bready,
    output axi_araddr, axi_arprot, axi_arvalid,
    input  axi_arready,
    input  axi_rdata, axi_rresp, axi_rvalid,
    output axi_rready
  );
endinterface

// File: rtl/ntps_axi_regbank.sv
// AXI4-Lite slave register bank: ID/build info, scratch, control word and a
// 64-bit cycle counter whose upper half is read through a shadow register.
module ntps_axi_regbank #(
  parameter logic [31:0] BUILD_INFO = 32'h0,
  parameter logic [31:0] GIT_HASH   = 32'h0,
  parameter logic [31:0] CTRL_RESET = 32'h0
) (
  input  logic                      axi_aclk,
  input  logic                      axi_aresetn,
  ntps_axi_regbank_if.slave         s_axi,
  output logic [31:0]               ctrl_out
);

  localparam logic [31:0] NAME_VAL    = 32'h6e747073;
  localparam logic [31:0] VERSION_VAL = 32'h00010000;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    REG_NAME    = 3'd0,
    REG_VERSION = 3'd1,
    REG_BUILD   = 3'd2,
    REG_GIT     = 3'd3,
    REG_SCRATCH = 3'd4,
    REG_CTRL    = 3'd5,
    REG_CNT_LO  = 3'd6,
    REG_CNT_HI  = 3'd7
  } reg_idx_e;

  logic        r_aw_full;
  logic [2:0]  r_aw_idx;
  logic        r_w_full;
  logic [31:0] r_w_data;
  logic [3:0]  r_w_strb;
  logic        r_bvalid;
  logic [1:0]  r_bresp;
  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic [31:0] r_scratch;
  logic [31:0] r_ctrl;
  logic [63:0] r_cnt;
  logic [31:0] r_cnt_shadow;

  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_do_write;
  logic [2:0]  w_wr_idx;
  logic [31:0] w_wr_data;
  logic [3:0]  w_wr_strb;
  logic        w_ar_hs;
  logic [31:0] w_rd_data;
  logic        w_unused;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int unsigned i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  assign s_axi.axi_awready = !r_aw_full && !r_bvalid;
  assign s_axi.axi_wready  = !r_w_full && !r_bvalid;
  assign s_axi.axi_bvalid  = r_bvalid;
  assign s_axi.axi_bresp   = r_bresp;
  assign s_axi.axi_arready = !r_rvalid;
  assign s_axi.axi_rvalid  = r_rvalid;
  assign s_axi.axi_rdata   = r_rdata;
  assign s_axi.axi_rresp   = r_rresp;
  assign ctrl_out          = r_ctrl;

  assign w_aw_hs = s_axi.axi_awvalid && s_axi.axi_awready;
  assign w_w_hs  = s_axi.axi_wvalid && s_axi.axi_wready;
  assign w_ar_hs = s_axi.axi_arvalid && s_axi.axi_arready;

  // A half arriving this edge bypasses its hold so the write completes
  // without an extra cycle.
  assign w_do_write = (r_aw_full || w_aw_hs) && (r_w_full || w_w_hs);
  assign w_wr_idx   = r_aw_full ? r_aw_idx : s_axi.axi_awaddr[4:2];
  assign w_wr_data  = r_w_full ? r_w_data : s_axi.axi_wdata;
  assign w_wr_strb  = r_w_full ? r_w_strb : s_axi.axi_wstrb;

  assign w_unused = ^{s_axi.axi_awprot, s_axi.axi_arprot,
                      s_axi.axi_awaddr[1:0], s_axi.axi_araddr[1:0]};

  always_comb begin
    w_rd_data = '0;
    unique case (reg_idx_e'(s_axi.axi_araddr[4:2]))
      REG_NAME:    w_rd_data = NAME_VAL;
      REG_VERSION: w_rd_data = VERSION_VAL;
      REG_BUILD:   w_rd_data = BUILD_INFO;
      REG_GIT:     w_rd_data = GIT_HASH;
      REG_SCRATCH: w_rd_data = r_scratch;
      REG_CTRL:    w_rd_data = r_ctrl;
      REG_CNT_LO:  w_rd_data = r_cnt[31:0];
      REG_CNT_HI:  w_rd_data = r_cnt_shadow;
      default:     w_rd_data = '0;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_aw_full <= 1'b0;
      r_aw_idx  <= '0;
      r_w_full  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_scratch <= '0;
      r_ctrl    <= CTRL_RESET;
    end else begin
      if (r_bvalid && s_axi.axi_bready) r_bvalid <= 1'b0;
      if (w_do_write) begin
        r_aw_full <= 1'b0;
        r_w_full  <= 1'b0;
        r_bvalid  <= 1'b1;
        unique case (reg_idx_e'(w_wr_idx))
          REG_SCRATCH: begin
            r_scratch <= merge_bytes(r_scratch, w_wr_data, w_wr_strb);
            r_bresp   <= RESP_OKAY;
          end
          REG_CTRL: begin
            r_ctrl  <= merge_bytes(r_ctrl, w_wr_data, w_wr_strb);
            r_bresp <= RESP_OKAY;
          end
          default: r_bresp <= RESP_SLVERR;
        endcase
      end else begin
        if (w_aw_hs) begin
          r_aw_full <= 1'b1;
          r_aw_idx  <= s_axi.axi_awaddr[4:2];
        end
        if (w_w_hs) begin
          r_w_full <= 1'b1;
          r_w_data <= s_axi.axi_wdata;
          r_w_strb <= s_axi.axi_wstrb;
        end
      end
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_rvalid     <= 1'b0;
      r_rdata      <= '0;
      r_rresp      <= RESP_OKAY;
      r_cnt        <= '0;
      r_cnt_shadow <= '0;
    end else begin
      r_cnt <= r_cnt + 64'd1;
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
        r_rresp  <= RESP_OKAY;
        // Shadow takes the same counter sample whose low half is returned.
        if (reg_idx_e'(s_axi.axi_araddr[4:2]) == REG_CNT_LO)
          r_cnt_shadow <= r_cnt[63:32];
      end else if (r_rvalid && s_axi.axi_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ntps_axi_regbank.sv
// Directed self-checking bench for ntps_axi_regbank.
module tb_ntps_axi_regbank;

  localparam logic [31:0] BUILD = 32'h20200101;
  localparam logic [31:0] GIT   = 32'hdeadbeef;
  localparam logic [31:0] CRST  = 32'ha5a50000;

  logic        clk;
  logic        rst_n;
  logic [31:0] ctrl_out;
  int          n_checks;
  int          n_errors;

  ntps_axi_regbank_if bus ();

  ntps_axi_regbank #(
    .BUILD_INFO (BUILD),
    .GIT_HASH   (GIT),
    .CTRL_RESET (CRST)
  ) dut (
    .axi_aclk    (clk),
    .axi_aresetn (rst_n),
    .s_axi       (bus),
    .ctrl_out    (ctrl_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r);
    @(negedge clk);
    bus.axi_araddr  = a;
    bus.axi_arvalid = 1'b1;
    bus.axi_rready  = 1'b0;
    @(posedge clk);
    #1;
    bus.axi_arvalid = 1'b0;
    chk("rvalid_after_ar", {63'd0, bus.axi_rvalid}, 64'd1);
    d = bus.axi_rdata;
    r = bus.axi_rresp;
    bus.axi_rready = 1'b1;
    @(posedge clk);
    #1;
    bus.axi_rready = 1'b0;
    chk("rvalid_cleared", {63'd0, bus.axi_rvalid}, 64'd0);
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] r, output logic [31:0] c);
    @(negedge clk);
    bus.axi_awaddr  = a;
    bus.axi_awvalid = 1'b1;
    bus.axi_wdata   = d;
    bus.axi_wstrb   = s;
    bus.axi_wvalid  = 1'b1;
    bus.axi_bready  = 1'b1;
    @(posedge clk);
    #1;
    bus.axi_awvalid = 1'b0;
    bus.axi_wvalid  = 1'b0;
    chk("bvalid_after_aw_w", {63'd0, bus.axi_bvalid}, 64'd1);
    r = bus.axi_bresp;
    c = ctrl_out;
    @(posedge clk);
    #1;
    bus.axi_bready = 1'b0;
    chk("bvalid_cleared", {63'd0, bus.axi_bvalid}, 64'd0);
  endtask

  logic [31:0] rd;
  logic [1:0]  rr;
  logic [31:0] cv;
  logic [31:0] lo1, hi1, lo2, hi2;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.axi_awaddr = '0; bus.axi_awprot = '0; bus.axi_awvalid = 1'b0;
    bus.axi_wdata = '0;  bus.axi_wstrb = '0;  bus.axi_wvalid = 1'b0;
    bus.axi_bready = 1'b0;
    bus.axi_araddr = '0; bus.axi_arprot = '0; bus.axi_arvalid = 1'b0;
    bus.axi_rready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bvalid",  {63'd0, bus.axi_bvalid},  64'd0);
    chk("rst_rvalid",  {63'd0, bus.axi_rvalid},  64'd0);
    chk("rst_awready", {63'd0, bus.axi_awready}, 64'd1);
    chk("rst_wready",  {63'd0, bus.axi_wready},  64'd1);
    chk("rst_arready", {63'd0, bus.axi_arready}, 64'd1);
    chk("rst_rdata",   {32'd0, bus.axi_rdata},   64'd0);
    chk("rst_ctrl",    {32'd0, ctrl_out},        {32'd0, CRST});
    @(negedge clk);
    rst_n = 1'b1;

    // Identification registers
    do_read(5'h00, rd, rr); chk("rd_name",    {32'd0, rd}, 64'h6e747073); chk("rresp_name", {62'd0, rr}, 64'd0);
    do_read(5'h04, rd, rr); chk("rd_version", {32'd0, rd}, 64'h00010000); chk("rresp_ver",  {62'd0, rr}, 64'd0);
    do_read(5'h08, rd, rr); chk("rd_build",   {32'd0, rd}, 64'h20200101); chk("rresp_bld",  {62'd0, rr}, 64'd0);
    do_read(5'h0F, rd, rr); chk("rd_git_lowbits_ignored", {32'd0, rd}, 64'hdeadbeef);

    // Byte-strobed scratch write
    do_write(5'h10, 32'h0, 4'hF, rr, cv);         chk("bresp_scr0", {62'd0, rr}, 64'd0);
    do_write(5'h10, 32'hcafef00d, 4'b0101, rr, cv); chk("bresp_scr1", {62'd0, rr}, 64'd0);
    do_read(5'h10, rd, rr); chk("rd_scratch_strb", {32'd0, rd}, 64'h00fe000d);

    // W three cycles ahead of AW, bready held low
    @(negedge clk);
    bus.axi_awaddr = 5'h10; bus.axi_wdata = 32'h12345678; bus.axi_wstrb = 4'hF;
    bus.axi_wvalid = 1'b1;  bus.axi_bready = 1'b0;
    @(negedge clk);
    bus.axi_wvalid = 1'b0;
    chk("w_held_wready", {63'd0, bus.axi_wready},  64'd0);
    chk("w_held_awrdy",  {63'd0, bus.axi_awready}, 64'd1);
    @(negedge clk);
    chk("w_held_nob", {63'd0, bus.axi_bvalid}, 64'd0);
    @(negedge clk);
    bus.axi_awvalid = 1'b1;
    @(negedge clk);
    bus.axi_awvalid = 1'b0;
    chk("late_aw_bvalid", {63'd0, bus.axi_bvalid}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("bpend_bvalid",  {63'd0, bus.axi_bvalid},  64'd1);
      chk("bpend_bresp",   {62'd0, bus.axi_bresp},   64'd0);
      chk("bpend_awready", {63'd0, bus.axi_awready}, 64'd0);
      chk("bpend_wready",  {63'd0, bus.axi_wready},  64'd0);
      @(negedge clk);
    end
    bus.axi_bready = 1'b1;
    @(negedge clk);
    chk("b_done", {63'd0, bus.axi_bvalid}, 64'd0);
    bus.axi_bready = 1'b0;
    @(negedge clk);
    chk("single_b", {63'd0, bus.axi_bvalid}, 64'd0);
    chk("awready_back", {63'd0, bus.axi_awready}, 64'd1);
    do_read(5'h10, rd, rr); chk("rd_scratch_late", {32'd0, rd}, 64'h12345678);

    // Read-only write and CTRL write
    do_write(5'h08, 32'h11111111, 4'hF, rr, cv); chk("bresp_ro", {62'd0, rr}, 64'd2);
    do_read(5'h08, rd, rr); chk("rd_build_after_wr", {32'd0, rd}, 64'h20200101);
    do_write(5'h14, 32'h1, 4'hF, rr, cv);
    chk("bresp_ctrl", {62'd0, rr}, 64'd0);
    chk("ctrl_out_1", {32'd0, cv}, 64'd1);

    // Simultaneous CTRL write and CTRL read: read sees old value
    @(negedge clk);
    bus.axi_awaddr = 5'h14; bus.axi_wdata = 32'h2; bus.axi_wstrb = 4'hF;
    bus.axi_awvalid = 1'b1; bus.axi_wvalid = 1'b1; bus.axi_bready = 1'b1;
    bus.axi_araddr = 5'h14; bus.axi_arvalid = 1'b1; bus.axi_rready = 1'b0;
    @(posedge clk);
    #1;
    bus.axi_awvalid = 1'b0; bus.axi_wvalid = 1'b0; bus.axi_arvalid = 1'b0;
    chk("same_cyc_rdata", {32'd0, bus.axi_rdata}, 64'd1);
    chk("same_cyc_ctrl",  {32'd0, ctrl_out},      64'd2);
    chk("same_cyc_bvalid", {63'd0, bus.axi_bvalid}, 64'd1);
    bus.axi_rready = 1'b1;
    @(posedge clk);
    #1;
    bus.axi_rready = 1'b0; bus.axi_bready = 1'b0;

    // Counter across the low-word carry
    @(negedge clk);
    force dut.r_cnt = 64'h0000_0000_ffff_ffff;
    #1;
    release dut.r_cnt;
    bus.axi_araddr = 5'h18; bus.axi_arvalid = 1'b1;
    @(posedge clk);
    #1;
    bus.axi_arvalid = 1'b0;
    lo1 = bus.axi_rdata;
    chk("cnt_lo_pre_wrap", {32'd0, lo1}, 64'hffffffff);
    bus.axi_rready = 1'b1;
    @(posedge clk);
    #1;
    bus.axi_rready = 1'b0;
    do_read(5'h1C, hi1, rr); chk("cnt_hi_pre_wrap", {32'd0, hi1}, 64'd0);
    do_read(5'h18, lo2, rr); chk("cnt_lo_post_wrap", {32'd0, lo2}, 64'd3);
    do_read(5'h1C, hi2, rr); chk("cnt_hi_post_wrap", {32'd0, hi2}, 64'd1);
    chk("cnt_monotonic", {63'd0, ({hi2, lo2} > {hi1, lo1})}, 64'd1);

    // Reset while a read response is stalled
    @(negedge clk);
    bus.axi_araddr = 5'h00; bus.axi_arvalid = 1'b1; bus.axi_rready = 1'b0;
    @(negedge clk);
    bus.axi_arvalid = 1'b0;
    chk("stall_rvalid", {63'd0, bus.axi_rvalid}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_rvalid", {63'd0, bus.axi_rvalid}, 64'd0);
    chk("async_rst_ctrl",   {32'd0, ctrl_out},       {32'd0, CRST});
    chk("async_rst_arrdy",  {63'd0, bus.axi_arready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    do_read(5'h10, rd, rr); chk("scratch_after_rst", {32'd0, rd}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
